// File: rtl/spi_peripheral_responder_if.sv
// SPI pins plus the local write-report and read ports of the SPI responder.
// The slave modport is the responder's view and the master modport is the controller's view.
interface spi_peripheral_responder_if #(
  parameter int unsigned REG_WIDTH = 16
);
  logic                 spi_clk;
  logic                 cs_b;
  logic                 pico;
  logic                 poci;
  logic                 busy;
  logic                 wr_valid;
  logic [9:0]           wr_addr;
  logic [REG_WIDTH-1:0] wr_data;
  logic                 frame_err;
  logic [9:0]           local_rd_addr;
  logic [REG_WIDTH-1:0] local_rd_data;

  modport slave (
    input  spi_clk, cs_b, pico, local_rd_addr,
    output poci, busy, wr_valid, wr_addr, wr_data, frame_err, local_rd_data
  );

  modport master (
    output spi_clk, cs_b, pico, local_rd_addr,
    input  poci, busy, wr_valid, wr_addr, wr_data, frame_err, local_rd_data
  );
endinterface

// File: rtl/spi_peripheral_responder.sv
// SPI responder with an oversampled front end, a frame decoder and a local register file.
// All logic runs on axi_clk; spi_clk is only sampled as data.
module spi_peripheral_responder #(
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned NUM_REGS  = 64
) (
  input logic                        axi_clk,
  input logic                        reset_b,
  spi_peripheral_responder_if.slave  bus
);
  localparam int unsigned CntW    = $clog2(REG_WIDTH + 12);
  localparam int unsigned IdxW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [10:0] NumRegs = 11'(NUM_REGS);

  typedef enum logic [1:0] {StIdle, StHeader, StWrData, StRdData} state_e;

  state_e               state_q;
  logic                 sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic                 cs_s1_q, cs_s2_q, cs_prev_q;
  logic                 pico_s1_q, pico_s2_q;
  logic [CntW-1:0]      bit_cnt_q;
  logic [9:0]           hdr_q;
  logic [9:0]           addr_q;
  logic [REG_WIDTH-1:0] shift_q;
  logic                 reload_q;
  logic                 poci_q, busy_q, wr_valid_q, frame_err_q;
  logic [9:0]           wr_addr_q;
  logic [REG_WIDTH-1:0] wr_data_q, local_rd_q;
  logic [REG_WIDTH-1:0] regs_q [NUM_REGS];

  logic                 sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [REG_WIDTH-1:0] shift_in, hdr_word, next_word;
  logic [9:0]           hdr_addr, addr_inc;
  logic                 hdr_ok, next_ok, wr_ok, lrd_ok;

  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s2_q & sclk_prev_q;
  assign cs_fall   = ~cs_s2_q & cs_prev_q;
  assign cs_rise   = cs_s2_q & ~cs_prev_q;

  assign shift_in  = {shift_q[REG_WIDTH-2:0], pico_s2_q};
  // hdr_q[9] holds WnR once ten header bits are in; the live pico bit is addr[0].
  assign hdr_addr  = {hdr_q[8:0], pico_s2_q};
  assign addr_inc  = addr_q + 10'd1;

  assign hdr_ok    = {1'b0, hdr_addr} < NumRegs;
  assign next_ok   = {1'b0, addr_inc} < NumRegs;
  assign wr_ok     = {1'b0, addr_q} < NumRegs;
  assign lrd_ok    = {1'b0, bus.local_rd_addr} < NumRegs;
  assign hdr_word  = hdr_ok  ? regs_q[hdr_addr[IdxW-1:0]] : '0;
  assign next_word = next_ok ? regs_q[addr_inc[IdxW-1:0]] : '0;

  always_ff @(posedge axi_clk or negedge reset_b) begin
    if (!reset_b) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_s1_q     <= 1'b0;
      cs_s2_q     <= 1'b0;
      cs_prev_q   <= 1'b0;
      pico_s1_q   <= 1'b0;
      pico_s2_q   <= 1'b0;
    end else begin
      sclk_s1_q   <= bus.spi_clk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      cs_s1_q     <= bus.cs_b;
      cs_s2_q     <= cs_s1_q;
      cs_prev_q   <= cs_s2_q;
      pico_s1_q   <= bus.pico;
      pico_s2_q   <= pico_s1_q;
    end
  end

  always_ff @(posedge axi_clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      hdr_q       <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      reload_q    <= 1'b0;
      poci_q      <= 1'b0;
      busy_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (cs_rise && state_q != StIdle) begin
        // A non-zero bit count means a partial word: drop it and flag the frame.
        frame_err_q <= (bit_cnt_q != '0);
        state_q     <= StIdle;
        busy_q      <= 1'b0;
        poci_q      <= 1'b0;
        bit_cnt_q   <= '0;
        reload_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cs_fall) begin
              state_q   <= StHeader;
              bit_cnt_q <= '0;
              hdr_q     <= '0;
              shift_q   <= '0;
              busy_q    <= 1'b1;
            end
          end
          StHeader: begin
            if (sclk_rise) begin
              if (bit_cnt_q == CntW'(10)) begin
                addr_q    <= hdr_addr;
                bit_cnt_q <= '0;
                if (hdr_q[9]) begin
                  state_q <= StWrData;
                end else begin
                  state_q  <= StRdData;
                  shift_q  <= hdr_word;
                  reload_q <= 1'b0;
                end
              end else begin
                hdr_q     <= {hdr_q[8:0], pico_s2_q};
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          StWrData: begin
            if (sclk_rise) begin
              if (bit_cnt_q == CntW'(REG_WIDTH - 1)) begin
                if (wr_ok) regs_q[addr_q[IdxW-1:0]] <= shift_in;
                wr_valid_q <= 1'b1;
                wr_addr_q  <= addr_q;
                wr_data_q  <= shift_in;
                addr_q     <= addr_inc;
                bit_cnt_q  <= '0;
              end else begin
                shift_q    <= shift_in;
                bit_cnt_q  <= bit_cnt_q + 1'b1;
              end
            end
          end
          StRdData: begin
            // Rises count bits the controller has sampled; falls drive the next bit.
            if (sclk_rise) begin
              if (bit_cnt_q == CntW'(REG_WIDTH - 1)) begin
                bit_cnt_q <= '0;
                reload_q  <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
            if (sclk_fall) begin
              if (reload_q) begin
                poci_q   <= next_word[REG_WIDTH-1];
                shift_q  <= {next_word[REG_WIDTH-2:0], 1'b0};
                addr_q   <= addr_inc;
                reload_q <= 1'b0;
              end else begin
                poci_q   <= shift_q[REG_WIDTH-1];
                shift_q  <= {shift_q[REG_WIDTH-2:0], 1'b0};
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge axi_clk or negedge reset_b) begin
    if (!reset_b) begin
      local_rd_q <= '0;
    end else begin
      local_rd_q <= lrd_ok ? regs_q[bus.local_rd_addr[IdxW-1:0]] : '0;
    end
  end

  assign bus.poci          = poci_q;
  assign bus.busy          = busy_q;
  assign bus.wr_valid      = wr_valid_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.local_rd_data = local_rd_q;
endmodule

// File: doc/spi_peripheral_responder.md
Name: spi_peripheral_responder

Overview:
- Target-side (responder) end of the SP3A-style SPI link: decodes frames from the SPI controller and serves a local register file.
- Used as an on-FPGA loopback/emulation target for controller bring-up.
- Also usable as a configuration slave for FPGA-side logic.
- Oversamples spi_clk/cs_b/pico in the system clock domain; no logic is clocked by spi_clk.

Parameters:
- REG_WIDTH, 16, bits per register and per SPI data word.
- NUM_REGS, 64, implemented registers at addresses 0..NUM_REGS-1 (NUM_REGS <= 1024).

Ports:
- axi_clk  input  1  system clock; spi_clk half-period >= 4 axi_clk cycles.
- reset_b  input  1  asynchronous, active-low reset.
- spi_clk  input  1  SPI clock from controller, mode 0 (idle low).
- cs_b  input  1  active-low chip select.
- pico  input  1  controller-to-peripheral data, MSB first.
- poci  output  1  peripheral-to-controller data, MSB first.
- busy  output  1  high while a frame is in progress (cs_b synchronized low).
- wr_valid  output  1  one-cycle pulse per completed SPI write word.
- wr_addr  output  10  address of the word reported by wr_valid.
- wr_data  output  REG_WIDTH  data of the word reported by wr_valid.
- frame_err  output  1  one-cycle pulse when cs_b rises mid-word.
- local_rd_addr  input  10  design-side read address.
- local_rd_data  output  REG_WIDTH  registered read data, 1-cycle latency; 0 when the address is out of range.

Behaviour:
- Input conditioning:
  - spi_clk, cs_b and pico each pass through a 2-FF synchronizer.
  - Rise/fall events come from the synchronized spi_clk versus its previous value.
  - pico is sampled on the rise event; poci is updated on the fall event.
- Frame format:
  - Bit 0: WnR (1 = write).
  - Bits 1..10: address[9:0].
  - Then N words of REG_WIDTH bits; N is set by the controller through cs_b deassertion.
- Address auto-increments after each word; 10-bit wrap, 1023 -> 0.
- States: IDLE, HEADER, WR_DATA, RD_DATA.
  - IDLE -> HEADER: synchronized cs_b falls. Bit counter and shift register are cleared; busy=1.
  - HEADER: shifts 11 bits on rise events.
    - On the 11th rise, go to WR_DATA if WnR=1, else RD_DATA.
    - For a read, load the shift register with reg[addr] on the same cycle.
  - WR_DATA: shifts REG_WIDTH bits. On the last bit of each word:
    - Write the register if addr < NUM_REGS; out-of-range writes are dropped silently.
    - Pulse wr_valid with wr_addr/wr_data regardless of range.
    - Increment addr and clear the bit counter.
  - RD_DATA:
    - On each fall event, drive poci = shift MSB and shift left.
    - On the fall after the last bit of a word, reload from reg[addr+1]; 0 if out of range.
    - The first data MSB is driven on the fall following the 11th header rise.
  - Any state -> IDLE: synchronized cs_b rises.
    - If the bit counter is non-zero in HEADER or a data state (partial word), pulse frame_err and discard the partial word; no write, no wr_valid.
    - busy=0 on the following cycle.
- poci is 0 whenever not in RD_DATA.
- A write to reg[a] and local_rd_addr=a on the same cycle: local_rd_data returns the old value; the new value appears one cycle later.
- Reset values (asynchronous, on reset_b low):
  - state=IDLE; all registers and shift/bit counters = 0.
  - poci, busy, wr_valid, frame_err = 0; wr_addr=0, wr_data=0, local_rd_data=0.
- Reset asserted mid-frame aborts the frame with no wr_valid and no frame_err.
  - After release, the block waits in IDLE for a fresh cs_b falling edge; a cs_b that is already low does not start a frame.

Test Plan:
- Write 2 words (0xA5A5, 0x1234) starting at addr 3, then local_rd_addr=3,4 -> two wr_valid pulses (addr 3/0xA5A5, addr 4/0x1234); local_rd_data=0xA5A5 then 0x1234.
- SPI read of 2 words at addr 3 after the above -> poci shifts out 0xA5A5 then 0x1234, MSB first, valid at every rising spi_clk.
- Write 3 words at addr 62 with NUM_REGS=64 -> regs 62 and 63 written; addr 64 dropped but wr_valid reports addr 64; local read of 64 returns 0.
- Write at addr 1023 for 2 words -> wr_valid addr 1023 then 0; reg[0] updated.
- cs_b raised after 7 data bits of a write -> frame_err pulse, no wr_valid, target register unchanged, busy=0.
- reset_b pulsed low mid-read frame -> poci=0, busy=0 immediately; all registers read 0; a new frame after cs_b toggles high then low decodes correctly.
